// File: rtl/alu_result_writeback.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_writeback
// Purpose : Tag-tracks dual-lane ALU results, buffers them in a 2-push FIFO and
//           drains them as addressed memory writes with valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module alu_result_writeback #(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cfg_start,
    input  logic [ADDR_WIDTH-1:0]     i_base_addr,
    input  logic [ADDR_WIDTH:0]       i_num_results,
    input  logic [1:0]                i_alu_start,
    input  logic [2*DATA_WIDTH-1:0]   i_alu_data_0,
    input  logic [2*DATA_WIDTH-1:0]   i_alu_data_1,
    output logic                      o_wr_valid,
    input  logic                      i_wr_ready,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr,
    output logic [2*DATA_WIDTH-1:0]   o_wr_data,
    output logic                      o_issue_hold,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_CTR_W = ADDR_WIDTH + 1;
    localparam int C_SUM_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [ALU_LATENCY-1:0]     r_tag0;
    logic [ALU_LATENCY-1:0]     r_tag1;
    logic [2*DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]         r_rd_ptr;
    logic [C_PTR_W-1:0]         r_wr_ptr;
    logic [C_CNT_W-1:0]         r_count;
    logic [ADDR_WIDTH-1:0]      r_base;
    logic [C_CTR_W-1:0]         r_num;
    logic [C_CTR_W-1:0]         r_wr_count;
    logic [C_CTR_W-1:0]         r_push_count;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_overflow;

    logic                       w_tag0;
    logic                       w_tag1;
    logic                       w_run;
    logic                       w_wr_valid;
    logic                       w_pop;
    logic [C_CNT_W-1:0]         w_free;
    logic                       w_acc0;
    logic                       w_acc1;
    logic                       w_drop;
    logic [1:0]                 w_npush;
    logic [C_SUM_W-1:0]         w_inflight;

    assign w_tag0     = r_tag0[ALU_LATENCY-1];
    assign w_tag1     = r_tag1[ALU_LATENCY-1];
    assign w_run      = (r_state == S_RUN);
    assign w_wr_valid = w_run && (r_count != '0);
    assign w_pop      = w_wr_valid && i_wr_ready;

    // Free slots after this cycle's pop; lane 0 claims space before lane 1.
    assign w_free  = C_CNT_W'(FIFO_DEPTH) - r_count + C_CNT_W'(w_pop);
    assign w_acc0  = w_tag0 && w_run && (r_push_count < r_num) && (w_free != '0);
    assign w_acc1  = w_tag1 && w_run
                     && ((r_push_count + C_CTR_W'(w_acc0)) < r_num)
                     && (w_free > C_CNT_W'(w_acc0));
    assign w_drop  = (w_tag0 && !w_acc0) || (w_tag1 && !w_acc1);
    assign w_npush = {1'b0, w_acc0} + {1'b0, w_acc1};

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < ALU_LATENCY; i++) begin
            w_inflight = w_inflight + C_SUM_W'(r_tag0[i]) + C_SUM_W'(r_tag1[i]);
        end
    end

    assign o_issue_hold = (C_SUM_W'(r_count) + w_inflight) >= C_SUM_W'(FIFO_DEPTH - 2);
    assign o_wr_valid   = w_wr_valid;
    assign o_wr_addr    = r_base + r_wr_count[ADDR_WIDTH-1:0];
    assign o_wr_data    = w_wr_valid ? r_mem[r_rd_ptr] : '0;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag0 <= '0;
            r_tag1 <= '0;
        end else begin
            r_tag0[0] <= i_alu_start[0];
            r_tag1[0] <= i_alu_start[1];
            for (int i = 1; i < ALU_LATENCY; i++) begin
                r_tag0[i] <= r_tag0[i-1];
                r_tag1[i] <= r_tag1[i-1];
            end
        end
    end

    // Storage needs no reset: o_wr_data is gated by valid.
    always_ff @(posedge clk) begin
        if (w_acc0) begin
            r_mem[r_wr_ptr] <= i_alu_data_0;
        end
        if (w_acc1) begin
            r_mem[r_wr_ptr + C_PTR_W'(w_acc0)] <= i_alu_data_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + C_PTR_W'(w_pop);
            r_wr_ptr <= r_wr_ptr + C_PTR_W'(w_npush);
            r_count  <= r_count + C_CNT_W'(w_npush) - C_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_num        <= '0;
            r_wr_count   <= '0;
            r_push_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cfg_start) begin
                        r_base       <= i_base_addr;
                        r_num        <= i_num_results;
                        r_wr_count   <= '0;
                        r_push_count <= '0;
                        if (i_num_results == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_push_count <= r_push_count + C_CTR_W'(w_npush);
                    if (w_pop) begin
                        r_wr_count <= r_wr_count + C_CTR_W'(1);
                        if ((r_wr_count + C_CTR_W'(1)) == r_num) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // A drop in the same cycle as a new job start still reports.
            if (i_cfg_start) begin
                r_overflow <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_writeback.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_result_writeback
// Purpose : Directed, table-driven self-checking bench for alu_result_writeback.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_result_writeback;

    localparam int AW = 10;
    localparam int L  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     num_results;
    logic [1:0]      alu_start;
    logic [63:0]     alu_data_0;
    logic [63:0]     alu_data_1;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [63:0]     wr_data;
    logic            issue_hold;
    logic            busy;
    logic            done;
    logic            overflow;

    always #5 clk = ~clk;

    alu_result_writeback #(
        .DATA_WIDTH  (32),
        .ALU_LATENCY (L),
        .FIFO_DEPTH  (8),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_cfg_start   (cfg_start),
        .i_base_addr   (base_addr),
        .i_num_results (num_results),
        .i_alu_start   (alu_start),
        .i_alu_data_0  (alu_data_0),
        .i_alu_data_1  (alu_data_1),
        .o_wr_valid    (wr_valid),
        .i_wr_ready    (wr_ready),
        .o_wr_addr     (wr_addr),
        .o_wr_data     (wr_data),
        .o_issue_hold  (issue_hold),
        .o_busy        (busy),
        .o_done        (done),
        .o_overflow    (overflow)
    );

    // ALU stand-in: data paired with a start appears L cycles later.
    logic [63:0] d_in0, d_in1;
    logic [63:0] dl0 [L];
    logic [63:0] dl1 [L];
    always @(posedge clk) begin
        dl0[0] <= d_in0;
        dl1[0] <= d_in1;
        for (int i = 1; i < L; i++) begin
            dl0[i] <= dl0[i-1];
            dl1[i] <= dl1[i-1];
        end
    end
    assign alu_data_0 = dl0[L-1];
    assign alu_data_1 = dl1[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] q_addr [$];
    logic [63:0]   q_data [$];
    int            q_cyc  [$];
    int            done_cnt = 0;
    int            done_cyc = -1;
    always @(negedge clk) begin
        if (wr_valid && wr_ready) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
            q_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0]      base;
        logic [AW:0]        num;
        logic [1:0]         st0;
        logic [1:0]         st1;
        logic [3:0][63:0]   d;
        logic [2:0]         exp_n;
        logic [3:0][AW-1:0] ea;
        logic [3:0][63:0]   ed;
        logic               exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] n);
        base_addr   = b;
        num_results = n;
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input string nm);
        for (int i = 0; i < 60 && done_cnt == start_cnt; i++) tick();
        if (done_cnt == start_cnt) chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_job(input vec_t v, input int id);
        int qb, db, t0, idx;
        string s;
        s  = $sformatf("job%0d", id);
        qb = q_addr.size();
        db = done_cnt;
        wr_ready = 1'b1;
        start_job(v.base, v.num);
        chk({s, "_busy"}, 64'(busy), 64'd1);
        chk({s, "_ovf_clear"}, 64'(overflow), 64'd0);
        t0 = cyc;
        alu_start = v.st0; d_in0 = v.d[0]; d_in1 = v.d[1];
        tick();
        alu_start = v.st1; d_in0 = v.d[2]; d_in1 = v.d[3];
        tick();
        alu_start = 2'b00;
        wait_done(db, s);
        repeat (6) tick();
        chk({s, "_nwr"}, 64'(q_addr.size() - qb), 64'(v.exp_n));
        for (int i = 0; i < int'(v.exp_n); i++) begin
            idx = qb + i;
            chk({s, "_addr"}, (idx < q_addr.size()) ? 64'(q_addr[idx]) : '1, 64'(v.ea[i]));
            chk({s, "_data"}, (idx < q_data.size()) ? q_data[idx] : '1, v.ed[i]);
        end
        if (q_cyc.size() > qb) begin
            chk({s, "_latency"}, 64'(q_cyc[qb] - t0), 64'd4);
            chk({s, "_done_time"}, 64'(done_cyc - q_cyc[q_cyc.size()-1]), 64'd1);
        end
        chk({s, "_done_cnt"}, 64'(done_cnt - db), 64'd1);
        chk({s, "_busy_fall"}, 64'(busy), 64'd0);
        chk({s, "_ovf"}, 64'(overflow), 64'(v.exp_ovf));
    endtask

    task automatic set_vec(input int k, input logic [AW-1:0] b, input logic [AW:0] n,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input logic [63:0] d2, input logic [63:0] d3,
                           input logic [2:0] en, input logic ov);
        vecs[k].base = b;   vecs[k].num = n;
        vecs[k].st0 = s0;   vecs[k].st1 = s1;
        vecs[k].d[0] = d0;  vecs[k].d[1] = d1;
        vecs[k].d[2] = d2;  vecs[k].d[3] = d3;
        vecs[k].exp_n = en; vecs[k].exp_ovf = ov;
        vecs[k].ea = '0;    vecs[k].ed = '0;
    endtask

    localparam logic [63:0] A = 64'hA0A0_0000_1111_0001;
    localparam logic [63:0] B = 64'hB0B0_0000_2222_0002;
    localparam logic [63:0] C = 64'hC0C0_0000_3333_0003;
    localparam logic [63:0] D = 64'hD0D0_0000_4444_0004;

    initial begin
        int issued, qb, db;

        // Expected write lists below are worked out by hand from each stimulus.
        set_vec(0, 10'h010, 11'd1, 2'b01, 2'b00, 64'h4000_0000_0000_0000, 0, 0, 0, 3'd1, 1'b0);
        vecs[0].ea[0] = 10'h010; vecs[0].ed[0] = 64'h4000_0000_0000_0000;
        set_vec(1, 10'h100, 11'd4, 2'b11, 2'b11, A, B, C, D, 3'd4, 1'b0);
        vecs[1].ea[0] = 10'h100; vecs[1].ed[0] = A;
        vecs[1].ea[1] = 10'h101; vecs[1].ed[1] = B;
        vecs[1].ea[2] = 10'h102; vecs[1].ed[2] = C;
        vecs[1].ea[3] = 10'h103; vecs[1].ed[3] = D;
        set_vec(2, 10'h3FF, 11'd2, 2'b11, 2'b00, C, D, 0, 0, 3'd2, 1'b0);
        vecs[2].ea[0] = 10'h3FF; vecs[2].ed[0] = C;
        vecs[2].ea[1] = 10'h000; vecs[2].ed[1] = D;
        set_vec(3, 10'h020, 11'd1, 2'b01, 2'b10, A, 0, 0, B, 3'd1, 1'b1);
        vecs[3].ea[0] = 10'h020; vecs[3].ed[0] = A;
        set_vec(4, 10'h050, 11'd3, 2'b11, 2'b11, D, C, B, A, 3'd3, 1'b1);
        vecs[4].ea[0] = 10'h050; vecs[4].ed[0] = D;
        vecs[4].ea[1] = 10'h051; vecs[4].ed[1] = C;
        vecs[4].ea[2] = 10'h052; vecs[4].ed[2] = B;
        set_vec(5, 10'h060, 11'd2, 2'b10, 2'b10, 0, B, 0, C, 3'd2, 1'b0);
        vecs[5].ea[0] = 10'h060; vecs[5].ed[0] = B;
        vecs[5].ea[1] = 10'h061; vecs[5].ed[1] = C;

        rst = 1'b1; cfg_start = 1'b0; base_addr = '0; num_results = '0;
        alu_start = 2'b00; wr_ready = 1'b0; d_in0 = '0; d_in1 = '0;
        repeat (3) tick();
        chk("rst_valid", 64'(wr_valid), 64'd0);
        chk("rst_addr",  64'(wr_addr), 64'd0);
        chk("rst_data",  wr_data, 64'd0);
        chk("rst_hold",  64'(issue_hold), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        rst = 1'b0;
        tick();

        // Result arriving while idle is dropped and flagged.
        qb = q_addr.size();
        alu_start = 2'b01; d_in0 = A;
        tick();
        alu_start = 2'b00;
        repeat (6) tick();
        chk("idle_ovf", 64'(overflow), 64'd1);
        chk("idle_nwr", 64'(q_addr.size() - qb), 64'd0);

        for (int k = 0; k < 6; k++) run_job(vecs[k], k);

        // Zero-length job.
        qb = q_addr.size();
        start_job(10'h0AA, 11'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        tick();
        chk("zero_done_off", 64'(done), 64'd0);
        repeat (3) tick();
        chk("zero_nwr", 64'(q_addr.size() - qb), 64'd0);

        // Backpressure: dual issue whenever allowed while memory stalls.
        qb = q_addr.size();
        db = done_cnt;
        wr_ready = 1'b0;
        start_job(10'h200, 11'd6);
        issued = 0;
        for (int c = 0; c < 12; c++) begin
            if (!issue_hold) begin
                alu_start = 2'b11;
                d_in0 = 64'hB000_0000_0000_0000 | 64'(issued);
                d_in1 = 64'hB000_0000_0000_0000 | 64'(issued + 1);
                issued = issued + 2;
            end else begin
                alu_start = 2'b00;
            end
            tick();
        end
        alu_start = 2'b00;
        chk("bp_issued", 64'(issued), 64'd6);
        chk("bp_hold", 64'(issue_hold), 64'd1);
        chk("bp_ovf", 64'(overflow), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", 64'(wr_valid), 64'd1);
            chk("bp_addr_stable", 64'(wr_addr), 64'h200);
            chk("bp_data_stable", wr_data, 64'hB000_0000_0000_0000);
            tick();
        end
        wr_ready = 1'b1;
        wait_done(db, "bp");
        repeat (3) tick();
        chk("bp_nwr", 64'(q_addr.size() - qb), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk("bp_addr", (qb + i < q_addr.size()) ? 64'(q_addr[qb+i]) : '1, 64'h200 + 64'(i));
            chk("bp_data", (qb + i < q_data.size()) ? q_data[qb+i] : '1,
                64'hB000_0000_0000_0000 | 64'(i));
        end

        // Reset with 3 results buffered and 2 in flight.
        qb = q_addr.size();
        wr_ready = 1'b0;
        start_job(10'h300, 11'd8);
        alu_start = 2'b11; d_in0 = A; d_in1 = B;
        tick();
        alu_start = 2'b01; d_in0 = C;
        tick();
        alu_start = 2'b00;
        tick();
        tick();
        alu_start = 2'b11; d_in0 = D; d_in1 = A;
        tick();
        alu_start = 2'b00;
        chk("mid_valid_pre", 64'(wr_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_valid", 64'(wr_valid), 64'd0);
        chk("mid_addr",  64'(wr_addr), 64'd0);
        chk("mid_data",  wr_data, 64'd0);
        chk("mid_hold",  64'(issue_hold), 64'd0);
        chk("mid_busy",  64'(busy), 64'd0);
        chk("mid_done",  64'(done), 64'd0);
        chk("mid_ovf",   64'(overflow), 64'd0);
        rst = 1'b0;
        db = done_cnt;
        wr_ready = 1'b1;
        repeat (8) tick();
        chk("mid_nwr", 64'(q_addr.size() - qb), 64'd0);
        chk("mid_no_done", 64'(done_cnt - db), 64'd0);
        run_job(vecs[1], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
